// File: rtl/calcu16_pkg.sv
// Shared widths, fetch FSM state and queue entry type for the calcu16 front end.
package calcu16_pkg;

  localparam int INSTR_W = 26;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps from the top of the address space to zero.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue of {pc, instr}; flush empties it in a single cycle.
module fetch_queue
  import calcu16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t pushEntry,
  input  logic         pop,
  output logic         headValid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  fetch_entry_t slots [2];
  logic         wrPtr;
  logic         rdPtr;
  logic         pushEn;
  logic         popEn;

  assign headValid = (count != 2'd0);
  assign popEn     = pop & headValid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pushEn    = push & ((count != FULL) | popEn);
  assign head      = slots[rdPtr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (pushEn) wrPtr <= ~wrPtr;
      if (popEn)  rdPtr <= ~rdPtr;
      unique case ({pushEn, popEn})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) slots[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory requester feeding a
// two-entry instruction queue, with branch redirect and in-flight discard.
module fetch_unit
  import calcu16_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               memReq,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memAck,
  input  logic [INSTR_W-1:0] memData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instrOut,
  output logic [ADDR_W-1:0]  instrPc,
  input  logic               instrReady,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectPc
);

  fetch_state_e      state;
  logic              reqReg;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W-1:0] fetchPc;

  logic              headValid;
  fetch_entry_t      head;
  fetch_entry_t      pushEntry;
  logic [1:0]        count;

  logic              accept;
  logic              push;
  logic              pop;
  logic              flush;
  logic [2:0]        occAfter;
  logic              roomAfter;

  assign accept    = memAck & reqReg;
  assign pop       = headValid & instrReady;
  assign push      = accept & (state == ST_FETCH) & ~redirect;
  assign flush     = redirect & (state != ST_DRAIN);
  assign pushEntry = '{pc: fetchPc, instr: memData};

  // Occupancy at the end of this cycle, crediting a same-cycle pop as free space.
  assign occAfter  = 3'(count) + 3'(push) - 3'(pop);
  assign roomAfter = (occAfter < 3'(DEPTH));

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headValid (headValid),
    .head      (head),
    .count     (count)
  );

  // Reset primes the first request so it is on the bus in the first cycle
  // reset is low; the output gating below keeps it invisible while reset=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      reqReg  <= 1'b1;
      addrReg <= RESET_PC;
      fetchPc <= RESET_PC;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetchPc <= redirectPc;
            addrReg <= redirectPc;
            reqReg  <= 1'b1;
            state   <= ST_FETCH;
          end else if (roomAfter) begin
            addrReg <= fetchPc;
            reqReg  <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            fetchPc <= redirectPc;
            if (memAck) addrReg <= redirectPc;
            else        state   <= ST_DRAIN;
          end else if (memAck) begin
            fetchPc <= pc_incr(fetchPc);
            addrReg <= pc_incr(fetchPc);
            if (!roomAfter) begin
              reqReg <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          // The old request must complete; its data is dropped on arrival.
          if (redirect) fetchPc <= redirectPc;
          if (memAck) begin
            addrReg <= redirect ? redirectPc : fetchPc;
            state   <= ST_FETCH;
          end
        end
        default: begin
          reqReg <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign memReq     = reqReg & ~reset;
  assign memAddr    = reset ? RESET_PC : addrReg;
  assign instrValid = headValid;
  assign instrOut   = headValid ? head.instr : '0;
  assign instrPc    = headValid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a queue-level model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck = 1'b0;
  logic [25:0] memData = 26'd0;
  logic        instrValid;
  logic [25:0] instrOut;
  logic [15:0] instrPc;
  logic        instrReady = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = 16'h0000;

  int nTests = 0;
  int nFail  = 0;

  // Memory model controls
  int   ackDelay = 0;
  logic randMode = 1'b0;
  logic forceAck = 1'b0;
  int   waitCnt  = 0;
  int   curDelay = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .instrValid (instrValid),
    .instrOut   (instrOut),
    .instrPc    (instrPc),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPc (redirectPc)
  );

  always #5 clk = ~clk;

  // Memory answers after curDelay waiting cycles; data is address + 0x100.
  always @(negedge clk) begin
    #2;
    if (forceAck) begin
      memAck  = 1'b1;
      memData = 26'h2AAAAAA;
    end else if (memReq && waitCnt >= curDelay) begin
      memAck  = 1'b1;
      memData = {10'd0, memAddr} + 26'h100;
    end else begin
      memAck  = 1'b0;
      memData = 26'h3FFFFFF;
    end
  end

  always @(posedge clk) begin
    if (!memReq || memAck) begin
      waitCnt  <= 0;
      curDelay <= randMode ? int'($urandom_range(3, 0)) : ackDelay;
    end else begin
      waitCnt <= waitCnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick(); reset = 1'b1; redirect = 1'b0; #2;
    tick(); #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      nTests++;
      if (memReq !== 1'b0) begin nFail++; $display("FAIL reset_memReq: got %b want 0", memReq); end
      nTests++;
      if (memAddr !== RESET_PC) begin nFail++; $display("FAIL reset_memAddr: got %h want %h", memAddr, RESET_PC); end
      nTests++;
      if ({instrValid, instrOut, instrPc} !== 43'd0) begin
        nFail++; $display("FAIL reset_outputs: got v=%b i=%h pc=%h want all 0", instrValid, instrOut, instrPc);
      end
    end
  endtask

  task automatic test_stream();
    ackDelay = 0; randMode = 1'b0; instrReady = 1'b1;
    apply_reset();
    tick(); reset = 1'b0; #2;
    nTests++;
    if (memReq !== 1'b1 || memAddr !== RESET_PC) begin
      nFail++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/%h", memReq, memAddr, RESET_PC);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); #2;
      nTests++;
      if (instrValid !== 1'b1 || instrPc !== 16'(k) || instrOut !== 26'(k) + 26'h100) begin
        nFail++; $display("FAIL stream_pc%0d: got v=%b pc=%h i=%h want 1/%h/%h", k, instrValid, instrPc, instrOut, 16'(k), 26'(k) + 26'h100);
      end
    end
  endtask

  task automatic test_backpressure();
    ackDelay = 0; instrReady = 1'b0;
    apply_reset();
    tick(); reset = 1'b0; #2;
    tick(); #2;
    tick(); #2;
    nTests++;
    if (memReq !== 1'b0 || memAddr !== 16'h0002 || instrPc !== 16'h0000) begin
      nFail++; $display("FAIL bp_full: got req=%b addr=%h pc=%h want 0/0002/0000", memReq, memAddr, instrPc);
    end
    tick(); #2;
    nTests++;
    if (memReq !== 1'b0) begin nFail++; $display("FAIL bp_hold: got req=%b want 0", memReq); end
    tick(); instrReady = 1'b1; #2;
    nTests++;
    if (memReq !== 1'b0 || instrPc !== 16'h0000) begin
      nFail++; $display("FAIL bp_pop: got req=%b pc=%h want 0/0000", memReq, instrPc);
    end
    tick(); instrReady = 1'b0; #2;
    nTests++;
    if (memReq !== 1'b1 || memAddr !== 16'h0002 || instrValid !== 1'b1 || instrPc !== 16'h0001) begin
      nFail++; $display("FAIL bp_refetch: got req=%b addr=%h v=%b pc=%h want 1/0002/1/0001", memReq, memAddr, instrValid, instrPc);
    end
    tick(); #2;
    nTests++;
    if (memReq !== 1'b0 || memAddr !== 16'h0003 || instrPc !== 16'h0001) begin
      nFail++; $display("FAIL bp_refull: got req=%b addr=%h pc=%h want 0/0003/0001", memReq, memAddr, instrPc);
    end
  endtask

  task automatic test_redirect_drain();
    logic [15:0] expAddr;
    ackDelay = 3; instrReady = 1'b1;
    apply_reset();
    tick(); reset = 1'b0; #2;
    tick(); redirect = 1'b1; redirectPc = 16'h0040; #2;
    nTests++;
    if (memReq !== 1'b1 || memAddr !== 16'h0000) begin
      nFail++; $display("FAIL drain_redirect: got req=%b addr=%h want 1/0000", memReq, memAddr);
    end
    for (int w = 3; w <= 8; w++) begin
      tick(); redirect = 1'b0; #2;
      expAddr = (w <= 4) ? 16'h0000 : 16'h0040;
      nTests++;
      if (memReq !== 1'b1 || memAddr !== expAddr || instrValid !== 1'b0) begin
        nFail++; $display("FAIL drain_w%0d: got req=%b addr=%h v=%b want 1/%h/0", w, memReq, memAddr, instrValid, expAddr);
      end
    end
    tick(); #2;
    nTests++;
    if (instrValid !== 1'b1 || instrPc !== 16'h0040 || instrOut !== 26'h140) begin
      nFail++; $display("FAIL drain_head: got v=%b pc=%h i=%h want 1/0040/0000140", instrValid, instrPc, instrOut);
    end
  endtask

  task automatic test_redirect_ack();
    ackDelay = 0; instrReady = 1'b1;
    apply_reset();
    tick(); reset = 1'b0; #2;
    tick(); redirect = 1'b1; redirectPc = 16'h0040; #2;
    nTests++;
    if (instrValid !== 1'b1 || instrPc !== 16'h0000 || memReq !== 1'b1 || memAddr !== 16'h0001) begin
      nFail++; $display("FAIL rack_setup: got v=%b pc=%h req=%b addr=%h want 1/0000/1/0001", instrValid, instrPc, memReq, memAddr);
    end
    tick(); redirect = 1'b0; #2;
    nTests++;
    if (instrValid !== 1'b0 || memReq !== 1'b1 || memAddr !== 16'h0040) begin
      nFail++; $display("FAIL rack_flush: got v=%b req=%b addr=%h want 0/1/0040", instrValid, memReq, memAddr);
    end
    tick(); #2;
    nTests++;
    if (instrValid !== 1'b1 || instrPc !== 16'h0040 || instrOut !== 26'h140) begin
      nFail++; $display("FAIL rack_head: got v=%b pc=%h i=%h want 1/0040/0000140", instrValid, instrPc, instrOut);
    end
    tick(); #2;
    nTests++;
    if (instrPc !== 16'h0041) begin nFail++; $display("FAIL rack_next: got pc=%h want 0041", instrPc); end
  endtask

  task automatic test_wrap();
    ackDelay = 0; instrReady = 1'b1;
    apply_reset();
    tick(); reset = 1'b0; #2;
    tick(); #2;
    tick(); redirect = 1'b1; redirectPc = 16'hFFFF; #2;
    tick(); redirect = 1'b0; #2;
    nTests++;
    if (memAddr !== 16'hFFFF || instrValid !== 1'b0) begin
      nFail++; $display("FAIL wrap_req: got addr=%h v=%b want FFFF/0", memAddr, instrValid);
    end
    tick(); #2;
    nTests++;
    if (instrPc !== 16'hFFFF || instrOut !== 26'h100FF) begin
      nFail++; $display("FAIL wrap_top: got pc=%h i=%h want FFFF/00100FF", instrPc, instrOut);
    end
    tick(); #2;
    nTests++;
    if (instrPc !== 16'h0000 || instrOut !== 26'h100 || instrValid !== 1'b1) begin
      nFail++; $display("FAIL wrap_zero: got v=%b pc=%h i=%h want 1/0000/0000100", instrValid, instrPc, instrOut);
    end
  endtask

  task automatic test_reset_mid();
    ackDelay = 1; instrReady = 1'b0;
    apply_reset();
    tick(); reset = 1'b0; #2;
    tick(); #2;
    tick(); #2;
    nTests++;
    if (instrValid !== 1'b1 || memReq !== 1'b1 || memAddr !== 16'h0001) begin
      nFail++; $display("FAIL rmid_setup: got v=%b req=%b addr=%h want 1/1/0001", instrValid, memReq, memAddr);
    end
    tick(); reset = 1'b1; #2;
    tick(); forceAck = 1'b1; #2;
    nTests++;
    if (memReq !== 1'b0 || instrValid !== 1'b0 || instrOut !== 26'd0 || instrPc !== 16'd0 || memAddr !== RESET_PC) begin
      nFail++; $display("FAIL rmid_reset: got req=%b v=%b i=%h pc=%h addr=%h want 0/0/0/0/%h", memReq, instrValid, instrOut, instrPc, memAddr, RESET_PC);
    end
    tick(); forceAck = 1'b0; reset = 1'b0; #2;
    nTests++;
    if (memReq !== 1'b1 || memAddr !== RESET_PC || instrValid !== 1'b0) begin
      nFail++; $display("FAIL rmid_restart: got req=%b addr=%h v=%b want 1/%h/0", memReq, memAddr, instrValid, RESET_PC);
    end
    tick(); #2;
    tick(); #2;
    nTests++;
    if (instrValid !== 1'b1 || instrPc !== RESET_PC || instrOut !== {10'd0, RESET_PC} + 26'h100) begin
      nFail++; $display("FAIL rmid_first: got v=%b pc=%h i=%h want 1/%h", instrValid, instrPc, instrOut, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [41:0] q[$];
    logic [15:0] mpc;
    logic        mdisc;
    logic        expReq;
    logic        prevReq;
    logic        prevAck;
    logic [15:0] prevAddr;
    logic        acked;
    randMode = 1'b1; instrReady = 1'b0;
    apply_reset();
    tick(); reset = 1'b0;
    mpc = RESET_PC; mdisc = 1'b0; prevReq = 1'b0; prevAck = 1'b0; prevAddr = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      if (c != 0) tick();
      instrReady = ($urandom_range(9, 0) < 7);
      redirect   = ($urandom_range(15, 0) == 0);
      redirectPc = ($urandom_range(1, 0) != 0) ? 16'(32'hFFFE + $urandom_range(3, 0)) : 16'($urandom);
      #2;
      expReq = (q.size() < DEPTH);
      nTests++;
      if (instrValid !== (q.size() != 0)) begin
        nFail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instrValid, q.size() != 0);
      end
      nTests++;
      if (q.size() != 0) begin
        if ({instrPc, instrOut} !== q[0]) begin
          nFail++; $display("FAIL rnd_head c%0d: got pc=%h i=%h want pc=%h i=%h", c, instrPc, instrOut, q[0][41:26], q[0][25:0]);
        end
      end else if ({instrPc, instrOut} !== 42'd0) begin
        nFail++; $display("FAIL rnd_empty c%0d: got pc=%h i=%h want 0/0", c, instrPc, instrOut);
      end
      nTests++;
      if (memReq !== expReq) begin nFail++; $display("FAIL rnd_req c%0d: got %b want %b", c, memReq, expReq); end
      if (!mdisc) begin
        nTests++;
        if (memAddr !== mpc) begin nFail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, memAddr, mpc); end
      end
      if (prevReq && !prevAck) begin
        nTests++;
        if (memReq !== 1'b1 || memAddr !== prevAddr) begin
          nFail++; $display("FAIL rnd_stable c%0d: got req=%b addr=%h want 1/%h", c, memReq, memAddr, prevAddr);
        end
      end
      // Effect of the coming clock edge on the fetch stream.
      acked = memAck && expReq;
      if (redirect) begin
        if (expReq) mdisc = !acked;
        q.delete();
        mpc = redirectPc;
      end else begin
        if (q.size() != 0 && instrReady) void'(q.pop_front());
        if (acked) begin
          if (mdisc) mdisc = 1'b0;
          else begin
            q.push_back({mpc, memData});
            mpc = mpc + 16'd1;
          end
        end
      end
      prevReq = memReq; prevAck = memAck; prevAddr = memAddr;
    end
    redirect = 1'b0; randMode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the instruction queue depth; only 2 is supported.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memReq  output  1  fetch request to instruction memory.
REQ-006 memAddr  output  16  fetch word address; valid while memReq=1.
REQ-007 memAck  input  1  memory returns memData this cycle; only meaningful while memReq=1.
REQ-008 memData  input  26  fetched instruction word.
REQ-009 instrValid  output  1  head of the queue holds a valid instruction.
REQ-010 instrOut  output  26  head instruction word, feeding the instruction register.
REQ-011 instrPc  output  16  address of instrOut.
REQ-012 instrReady  input  1  control unit accepts the head; a pop occurs when instrValid=1 and instrReady=1.
REQ-013 redirect  input  1  branch/jump taken; flushes the queue and restarts fetch.
REQ-014 redirectPc  input  16  new fetch address, sampled when redirect=1.

Function
REQ-015 At most one memory request shall be outstanding at any time.
REQ-016 Once memReq is asserted, memReq and memAddr shall stay stable until the cycle memAck=1 inclusive.
REQ-017 memAck may arrive in the same cycle as memReq rises (zero-wait memory) or any number of cycles later.
REQ-018 A new request shall be issued only when queue occupancy plus outstanding requests is below DEPTH, counting a same-cycle pop as freed space.
REQ-019 On memAck with no discard pending: push {fetchPc, memData}; fetchPc += 1 mod 2^16 (16'hFFFF wraps to 16'h0000).
REQ-020 A pushed entry shall appear at the head with instrValid=1 in the cycle after memAck (1-cycle latency); a simultaneous push and pop is legal.
REQ-021 With zero-wait memory and instrReady held at 1, throughput shall be one instruction per cycle.
REQ-022 FSM states: IDLE (no request, queue has no room), FETCH (request outstanding), DRAIN (outstanding request whose data will be discarded).
REQ-023 Transitions: IDLE->FETCH when space frees; FETCH->IDLE on ack with no space left; FETCH->DRAIN on redirect without same-cycle ack; DRAIN->FETCH on ack.
REQ-024 On redirect: queue emptied (instrValid=0 next cycle) and fetchPc<=redirectPc; redirect overrides any same-cycle pop and push.
REQ-025 If redirect coincides with memAck, the returned word shall be discarded and a request to redirectPc issued the next cycle.
REQ-026 In DRAIN, memReq stays high at the old address; the ack data is discarded and the next cycle requests fetchPc.
REQ-027 A redirect received in DRAIN shall only update fetchPc.
REQ-028 When instrValid=0, instrOut and instrPc shall be 0.

Reset
REQ-029 While reset=1: memReq=0, memAddr=RESET_PC, instrValid=0, instrOut=0, instrPc=0, queue empty, state IDLE, discard cleared.
REQ-030 Reset overrides all other inputs, including mid-request; the outstanding request is abandoned and any later memAck is ignored until memReq reasserts.
REQ-031 In the first cycle after reset deasserts, memReq=1 with memAddr=RESET_PC.

Structure
REQ-032 Shared package calcu16_pkg shall hold INSTR_W=26, DATA_W=16, ADDR_W=16 and the FSM state typedef.
REQ-033 The queue shall be a separate sub-module fetch_queue (DEPTH-entry FIFO of {pc, instr}) with a flush input.

Verification
REQ-034 Zero-wait memory, instrReady=1, data=addr+26'h100 -> instrPc 0,1,2,3 on consecutive cycles, starting the second cycle after reset.
REQ-035 instrReady=0 -> after 2 pushes memReq=0 and memAddr=16'h0002; raise instrReady -> one pop, then a request to 16'h0002 follows.
REQ-036 Redirect to 16'h0040 while memAck is delayed 3 cycles -> memReq holds the old address, the returned word never appears, then memAddr=16'h0040.
REQ-037 redirect to 16'h0040 coincident with memAck and a pop -> instrValid=0 next cycle, then a request to 16'h0040; the acked word is never output.
REQ-038 Redirect to 16'hFFFF -> instrPc sequence 16'hFFFF, 16'h0000.
REQ-039 Reset asserted during an outstanding request -> memReq=0 and instrValid=0 next cycle; after release the first fetch is at RESET_PC.
